// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and header codes for the SPI packet decoder
package spi_pkg;
  typedef enum logic [1:0] {IDLE, XBYTES, YBYTES} state_e;
  localparam logic [2:0] HDR_CONF  = 3'b111;
  localparam logic [2:0] HDR_POINT = 3'b110;
endpackage

// File: rtl/spi_watchdog.sv
// spi_watchdog: inter-byte idle counter that pulses expire after TIMEOUT_CYCLES uncleared clocks
// Ports: clk, reset (sync, active-high), clear (restart count), expire (combinational pulse).
// Only built when SPI_DECODE_TIMEOUT_EN is defined.
`ifdef SPI_DECODE_TIMEOUT_EN
module spi_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    expire = !clear && cnt_q == CW'(TIMEOUT_CYCLES - 1);
    cnt_d  = (clear || expire) ? '0 : cnt_q + CW'(1);
  end
  always_ff @(posedge clk)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule
`endif

// File: rtl/spi_packet_decoder.sv
// spi_packet_decoder: turns SPI command bytes into brush/colour updates and atomic X/Y point packets
// Ports: clk, reset (sync, active-high), byteValid/spiByte (input byte strobe),
//   brush/color (config), x/y (last committed point), confValid/pointValid/error (1-cycle pulses),
//   busy (point packet in progress). Define SPI_DECODE_TIMEOUT_EN for the mid-packet watchdog.
module spi_packet_decoder
  import spi_pkg::*;
#(
  parameter int COORD_W        = 8,
  parameter int COLOR_W        = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               byteValid,
  input  logic [7:0]         spiByte,
  output logic               brush,
  output logic [COLOR_W-1:0] color,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               confValid,
  output logic               pointValid,
  output logic               error,
  output logic               busy
);
  localparam int NB = (COORD_W + 7) / 8;
  localparam int CW = $clog2(NB + 1);
  localparam int AW = NB * 8;
  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]      xacc_q, xacc_d, yacc_q, yacc_d;
  logic               brush_q, brush_d, conf_q, conf_d, point_q, point_d, err_q, err_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               last, expire;
`ifdef SPI_DECODE_TIMEOUT_EN
  spi_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .clear (byteValid || state_q == IDLE),
    .expire(expire)
  );
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign expire = 1'b0;
`endif
  assign last = cnt_q == CW'(NB - 1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xacc_d  = xacc_q;
    yacc_d  = yacc_q;
    brush_d = brush_q;
    color_d = color_q;
    x_d     = x_q;
    y_d     = y_q;
    conf_d  = 1'b0;
    point_d = 1'b0;
    err_d   = 1'b0;
    if (byteValid) begin
      if (state_q == IDLE) begin
        if (spiByte[7:5] == HDR_CONF) begin
          brush_d = spiByte[4];
          color_d = spiByte[COLOR_W-1:0];
          conf_d  = 1'b1;
        end else if (spiByte[7:5] == HDR_POINT) begin
          cnt_d   = '0;
          xacc_d  = '0;
          yacc_d  = '0;
          state_d = XBYTES;
        end else err_d = 1'b1;
      end else if (state_q == XBYTES) begin
        // Shift MSB-first; payload bytes are never treated as headers.
        xacc_d  = (xacc_q << 8) | AW'(spiByte);
        cnt_d   = last ? '0 : cnt_q + CW'(1);
        state_d = last ? YBYTES : XBYTES;
      end else begin
        yacc_d  = (yacc_q << 8) | AW'(spiByte);
        cnt_d   = last ? '0 : cnt_q + CW'(1);
        state_d = last ? IDLE : YBYTES;
        // Both coordinates commit on the same edge so x/y never show a half packet.
        if (last) begin
          x_d     = xacc_q[COORD_W-1:0];
          y_d     = yacc_d[COORD_W-1:0];
          point_d = 1'b1;
        end
      end
    end else if (expire) begin
      err_d   = 1'b1;
      state_d = IDLE;
      cnt_d   = '0;
      xacc_d  = '0;
      yacc_d  = '0;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      xacc_q  <= '0;
      yacc_q  <= '0;
      brush_q <= 1'b0;
      color_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      conf_q  <= 1'b0;
      point_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xacc_q  <= xacc_d;
      yacc_q  <= yacc_d;
      brush_q <= brush_d;
      color_q <= color_d;
      x_q     <= x_d;
      y_q     <= y_d;
      conf_q  <= conf_d;
      point_q <= point_d;
      err_q   <= err_d;
    end
  assign brush      = brush_q;
  assign color      = color_q;
  assign x          = x_q;
  assign y          = y_q;
  assign confValid  = conf_q;
  assign pointValid = point_q;
  assign error      = err_q;
  assign busy       = state_q != IDLE;
endmodule
